pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush/forward sequencer for the 5-stage core. Inputs are hazard-relevant IF/ID, ID/EX, EX/MEM, MEM/WB fields.
//  Outputs: per-register stall/flush, EX operand forward selects (forward_sel_t), PC redirect select, dmem request handshake.
//  Owns the only sequential hazard state: the data-memory access FSM and its timeout counter.
// PARAMETERS
//  DMEM_TIMEOUT  255  cycles in WAIT without ack before forced release; 0 = timeout disabled
//  CNT_W         32   width of perf counters (used only with PIPE_CTRL_PERF_EN)
// PORTS
//  clk_i              in   1   core clock
//  rst_i              in   1   synchronous, active-high reset
//  id_rs1_addr_i/id_rs2_addr_i  in 5   ID-stage source regs;  id_rs1_read_i/id_rs2_read_i  in 1  source used
//  ex_rs1_addr_i/ex_rs2_addr_i  in 5   EX-stage source regs (id_ex_t)
//  ex_valid_i, ex_is_mem_read_i, ex_is_rd_write_i  in 1;  ex_rd_addr_i  in 5
//  ex_mispredict_i    in   1   EX resolved branch/jump disagrees with branch_predict
//  mem_valid_i, mem_is_rd_write_i  in 1;  mem_rd_addr_i  in 5
//  mem_is_mem_access_i in  1   MEM-stage instr is load or store (valid qualified externally)
//  wb_valid_i, wb_is_rd_write_i  in 1;  wb_rd_addr_i  in 5
//  wb_trap_valid_i    in   1   trap retiring in WB
//  dmem_ack_i         in   1   data bus response (rdata/write done)
//  dmem_req_o         out  1   single-cycle request pulse to data bus
//  dmem_timeout_o     out  1   1-cycle pulse: WAIT expired
//  fwd_a_sel_o/fwd_b_sel_o  out 2   forward_sel_t for EX rs1/rs2
//  pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o  out 1  hold register
//  if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o  out 1  load reset_*() bubble
//  pc_redirect_o      out  2   0 none, 1 branch target (EX jaddr), 2 trap vector
// BEHAVIOUR
//  Reset: FSM=IDLE, counter=0, all outputs 0 (fwd sels NO_FORWARD_SEL, redirect 0).
//  Forwarding (comb): rsX!=0 & MEM valid & rd_write & rd==rsX -> FORWARD_SEL_MEM_RESULT; else same test vs WB
//   -> FORWARD_SEL_WB_RESULT; else NO_FORWARD_SEL. MEM has priority over WB.
//  Load-use (comb): ex_valid & ex_is_mem_read & ex_rd!=0 & matches an ID source with its read flag ->
//   pc_stall, if_id_stall, id_ex_flush (one bubble; load result then forwards from WB).
//  DMEM FSM states IDLE, WAIT, KILL:
//   IDLE: mem_is_mem_access_i & ~wb_trap_valid_i -> dmem_req_o=1 this cycle, go WAIT.
//   WAIT: pc/if_id/id_ex/ex_mem stall, mem_wb_flush. dmem_ack_i -> IDLE, no stall that cycle (MEM/WB captures).
//         counter increments each WAIT cycle; counter==DMEM_TIMEOUT-1 w/o ack -> dmem_timeout_o, release as ack.
//         wb_trap_valid_i in WAIT -> go KILL (outstanding access cannot be cancelled on the bus).
//   KILL: all four flushes held, pc_stall; on ack or timeout -> IDLE, response discarded.
//   Counter cleared on every entry to WAIT. Ack in IDLE is ignored.
//  Priority (high->low): trap > DMEM WAIT/KILL > mispredict > load-use.
//   Trap: flush all four registers, pc_redirect_o=2, same cycle; no dmem_req_o issued that cycle.
//   Mispredict honoured only when EX not stalled: if_id_flush, id_ex_flush, pc_redirect_o=1; load-use
//    suppressed that cycle. During WAIT, mispredict is held by EX and acts the cycle stall releases.
//  Stall and flush of the same register never both asserted; flush wins.
//  Reset mid-WAIT: FSM returns to IDLE, counter 0; bus side owned by its own reset.
// CONFIGURATION
//  PIPE_CTRL_PERF_EN defined: adds outputs perf_stall_cycles_o [CNT_W] (cycles with pc_stall_o=1) and
//   perf_flush_events_o [CNT_W] (cycles with pc_redirect_o!=0); both reset to 0, wrap at 2^CNT_W.
//  Undefined: ports and counters absent; no other behavioural difference.
// TESTING
//  ex load x5, id add x6,x5,x1 -> 1 cycle pc_stall/if_id_stall/id_ex_flush; next cycle fwd_a_sel=WB_RESULT.
//  mem add x7, wb add x7, ex uses x7 -> fwd sel MEM_RESULT; ex rs=x0 with mem rd=x0 -> NO_FORWARD_SEL.
//  load in MEM, ack after 3 cycles -> dmem_req_o 1 pulse, stalls 3 cycles, mem_wb_flush 3 cycles, release on ack.
//  DMEM_TIMEOUT=4, no ack -> dmem_timeout_o in 4th WAIT cycle, FSM IDLE next cycle.
//  wb_trap_valid_i during WAIT + ex_mispredict_i -> redirect=2, all flush, KILL until ack; no branch redirect.
//  ex_mispredict_i with concurrent load-use -> redirect=1, if_id/id_ex flush, no pc_stall.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Data-memory handshake between the hazard controller (master) and the data bus side (slave).
interface pipeline_hazard_ctrl_if;
   logic dmem_req;
   logic dmem_ack;
   logic dmem_timeout;

   modport master (
      output dmem_req,
      output dmem_timeout,
      input  dmem_ack
   );

   modport slave (
      input  dmem_req,
      input  dmem_timeout,
      output dmem_ack
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward sequencer for the 5-stage core; owns the data-memory access FSM and its timeout.
// Optional macro PIPE_CTRL_PERF_EN adds stall-cycle and redirect-event performance counters.
module pipeline_hazard_ctrl #(
   parameter int DMEM_TIMEOUT = 255,
   parameter int CNT_W        = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [4:0]             id_rs1_addr_i,
   input  logic [4:0]             id_rs2_addr_i,
   input  logic                   id_rs1_read_i,
   input  logic                   id_rs2_read_i,
   input  logic [4:0]             ex_rs1_addr_i,
   input  logic [4:0]             ex_rs2_addr_i,
   input  logic                   ex_valid_i,
   input  logic                   ex_is_mem_read_i,
   input  logic                   ex_is_rd_write_i,
   input  logic [4:0]             ex_rd_addr_i,
   input  logic                   ex_mispredict_i,
   input  logic                   mem_valid_i,
   input  logic                   mem_is_rd_write_i,
   input  logic [4:0]             mem_rd_addr_i,
   input  logic                   mem_is_mem_access_i,
   input  logic                   wb_valid_i,
   input  logic                   wb_is_rd_write_i,
   input  logic [4:0]             wb_rd_addr_i,
   input  logic                   wb_trap_valid_i,
   pipeline_hazard_ctrl_if.master dmem,
   output logic [1:0]             fwd_a_sel_o,
   output logic [1:0]             fwd_b_sel_o,
   output logic                   pc_stall_o,
   output logic                   if_id_stall_o,
   output logic                   id_ex_stall_o,
   output logic                   ex_mem_stall_o,
   output logic                   if_id_flush_o,
   output logic                   id_ex_flush_o,
   output logic                   ex_mem_flush_o,
   output logic                   mem_wb_flush_o,
   output logic [1:0]             pc_redirect_o
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [CNT_W-1:0]       perf_stall_cycles_o,
   output logic [CNT_W-1:0]       perf_flush_events_o
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_KILL = 2'd2
   } dmem_state_e;

   typedef enum logic [1:0] {
      NO_FORWARD_SEL         = 2'd0,
      FORWARD_SEL_MEM_RESULT = 2'd1,
      FORWARD_SEL_WB_RESULT  = 2'd2
   } forward_sel_t;

   localparam int TMO_W = (DMEM_TIMEOUT > 32'sd2) ? $clog2(DMEM_TIMEOUT) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST =
      TMO_W'((DMEM_TIMEOUT > 32'sd0) ? (DMEM_TIMEOUT - 32'sd1) : 32'sd0);

   if (DMEM_TIMEOUT < 32'sd0) begin : g_bad_timeout
      $error("DMEM_TIMEOUT must be non-negative");
   end
   if (CNT_W < 32'sd1) begin : g_bad_cnt_w
      $error("CNT_W must be at least 1");
   end

   dmem_state_e      state_q, state_d;
   logic [TMO_W-1:0] cnt_q, cnt_d;
   logic             expire_s;
   logic             load_use_s;
   logic             hold_s, kill_s, req_s, tmo_s;
   logic             pc_stall_s, if_id_stall_s, id_ex_stall_s, ex_mem_stall_s;
   logic             if_id_flush_s, id_ex_flush_s, ex_mem_flush_s, mem_wb_flush_s;
   logic [1:0]       redirect_s;
   logic             unused_ex_rd_write_s;

   // A load always writes rd, so the load-use test keys on the mem-read flag alone.
   assign unused_ex_rd_write_s = ex_is_rd_write_i;

   function automatic forward_sel_t fwd_sel(input logic [4:0] rs,
                                            input logic       mem_wr,
                                            input logic [4:0] mem_rd,
                                            input logic       wb_wr,
                                            input logic [4:0] wb_rd);
      if ((rs != 5'd0) && mem_wr && (mem_rd == rs)) begin
         return FORWARD_SEL_MEM_RESULT;
      end else if ((rs != 5'd0) && wb_wr && (wb_rd == rs)) begin
         return FORWARD_SEL_WB_RESULT;
      end else begin
         return NO_FORWARD_SEL;
      end
   endfunction

   assign fwd_a_sel_o = rst_i ? NO_FORWARD_SEL :
                        fwd_sel(ex_rs1_addr_i, mem_valid_i & mem_is_rd_write_i, mem_rd_addr_i,
                                wb_valid_i & wb_is_rd_write_i, wb_rd_addr_i);
   assign fwd_b_sel_o = rst_i ? NO_FORWARD_SEL :
                        fwd_sel(ex_rs2_addr_i, mem_valid_i & mem_is_rd_write_i, mem_rd_addr_i,
                                wb_valid_i & wb_is_rd_write_i, wb_rd_addr_i);

   assign load_use_s = ex_valid_i & ex_is_mem_read_i & (ex_rd_addr_i != 5'd0) &
                       ((id_rs1_read_i & (id_rs1_addr_i == ex_rd_addr_i)) |
                        (id_rs2_read_i & (id_rs2_addr_i == ex_rd_addr_i)));

   assign expire_s = (DMEM_TIMEOUT != 32'sd0) && (cnt_q == TMO_LAST);

   // DMEM FSM next state plus the prioritised stall/flush/redirect decision.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      req_s          = 1'b0;
      tmo_s          = 1'b0;
      hold_s         = 1'b0;
      kill_s         = 1'b0;
      pc_stall_s     = 1'b0;
      if_id_stall_s  = 1'b0;
      id_ex_stall_s  = 1'b0;
      ex_mem_stall_s = 1'b0;
      if_id_flush_s  = 1'b0;
      id_ex_flush_s  = 1'b0;
      ex_mem_flush_s = 1'b0;
      mem_wb_flush_s = 1'b0;
      redirect_s     = 2'd0;
      if (rst_i) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               // The issuing cycle already holds the pipe: the access owns MEM until its response.
               if (mem_is_mem_access_i && !wb_trap_valid_i) begin
                  req_s   = 1'b1;
                  hold_s  = 1'b1;
                  state_d = ST_WAIT;
                  cnt_d   = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_WAIT, ST_KILL: begin
               if (dmem.dmem_ack || expire_s) begin
                  tmo_s   = ~dmem.dmem_ack;
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d  = (DMEM_TIMEOUT != 32'sd0) ? (cnt_q + TMO_W'(1)) : cnt_q;
                  kill_s = (state_q == ST_KILL);
                  hold_s = (state_q == ST_WAIT);
                  if (wb_trap_valid_i) begin
                     state_d = ST_KILL;
                  end else begin
                     state_d = state_q;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase

         if (wb_trap_valid_i) begin
            if_id_flush_s  = 1'b1;
            id_ex_flush_s  = 1'b1;
            ex_mem_flush_s = 1'b1;
            mem_wb_flush_s = 1'b1;
            redirect_s     = 2'd2;
         end else if (hold_s) begin
            pc_stall_s     = 1'b1;
            if_id_stall_s  = 1'b1;
            id_ex_stall_s  = 1'b1;
            ex_mem_stall_s = 1'b1;
            mem_wb_flush_s = 1'b1;
         end else if (kill_s) begin
            pc_stall_s     = 1'b1;
            if_id_flush_s  = 1'b1;
            id_ex_flush_s  = 1'b1;
            ex_mem_flush_s = 1'b1;
            mem_wb_flush_s = 1'b1;
         end else if (ex_mispredict_i) begin
            if_id_flush_s  = 1'b1;
            id_ex_flush_s  = 1'b1;
            redirect_s     = 2'd1;
         end else if (load_use_s) begin
            pc_stall_s     = 1'b1;
            if_id_stall_s  = 1'b1;
            id_ex_flush_s  = 1'b1;
         end else begin
            redirect_s     = 2'd0;
         end
      end
   end

   // DMEM FSM state and WAIT/KILL cycle counter.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign dmem.dmem_req     = req_s;
   assign dmem.dmem_timeout = tmo_s;
   assign pc_stall_o        = pc_stall_s;
   assign if_id_stall_o     = if_id_stall_s;
   assign id_ex_stall_o     = id_ex_stall_s;
   assign ex_mem_stall_o    = ex_mem_stall_s;
   assign if_id_flush_o     = if_id_flush_s;
   assign id_ex_flush_o     = id_ex_flush_s;
   assign ex_mem_flush_o    = ex_mem_flush_s;
   assign mem_wb_flush_o    = mem_wb_flush_s;
   assign pc_redirect_o     = redirect_s;

`ifdef PIPE_CTRL_PERF_EN
   logic [CNT_W-1:0] perf_stall_q, perf_stall_d;
   logic [CNT_W-1:0] perf_flush_q, perf_flush_d;

   // Perf counter increments; both wrap naturally at 2^CNT_W.
   always_comb begin
      perf_stall_d = perf_stall_q + CNT_W'(pc_stall_s);
      perf_flush_d = perf_flush_q + CNT_W'(redirect_s != 2'd0);
   end

   // Perf counter registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
      end else begin
         perf_stall_q <= perf_stall_d;
         perf_flush_q <= perf_flush_d;
      end
   end

   assign perf_stall_cycles_o = perf_stall_q;
   assign perf_flush_events_o = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus random stimulus against a reference model.
module tb_pipeline_hazard_ctrl;
   localparam int TMO = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
   logic       id_rs1_rd, id_rs2_rd, ex_valid, ex_mem_read, ex_rd_wr, misp;
   logic       mem_valid, mem_rd_wr, mem_acc, wb_valid, wb_rd_wr, trap;
   logic [1:0] fwd_a, fwd_b, redirect;
   logic       pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
   logic       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;

   pipeline_hazard_ctrl_if dmem_if();

   pipeline_hazard_ctrl #(.DMEM_TIMEOUT(TMO), .CNT_W(32)) dut (
      .clk_i(clk), .rst_i(rst),
      .id_rs1_addr_i(id_rs1), .id_rs2_addr_i(id_rs2),
      .id_rs1_read_i(id_rs1_rd), .id_rs2_read_i(id_rs2_rd),
      .ex_rs1_addr_i(ex_rs1), .ex_rs2_addr_i(ex_rs2),
      .ex_valid_i(ex_valid), .ex_is_mem_read_i(ex_mem_read), .ex_is_rd_write_i(ex_rd_wr),
      .ex_rd_addr_i(ex_rd), .ex_mispredict_i(misp),
      .mem_valid_i(mem_valid), .mem_is_rd_write_i(mem_rd_wr), .mem_rd_addr_i(mem_rd),
      .mem_is_mem_access_i(mem_acc),
      .wb_valid_i(wb_valid), .wb_is_rd_write_i(wb_rd_wr), .wb_rd_addr_i(wb_rd),
      .wb_trap_valid_i(trap),
      .dmem(dmem_if),
      .fwd_a_sel_o(fwd_a), .fwd_b_sel_o(fwd_b),
      .pc_stall_o(pc_stall), .if_id_stall_o(if_id_stall), .id_ex_stall_o(id_ex_stall),
      .ex_mem_stall_o(ex_mem_stall),
      .if_id_flush_o(if_id_flush), .id_ex_flush_o(id_ex_flush), .ex_mem_flush_o(ex_mem_flush),
      .mem_wb_flush_o(mem_wb_flush),
      .pc_redirect_o(redirect)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fails  = 0;
   logic [15:0] exp_v, obs_v;

   // Reference model: an access is either absent, pending, or pending-but-killed, with a count of waited cycles.
   bit m_pend, m_kill;
   int m_waits;

   function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
      if (rs != 5'd0 && mem_valid && mem_rd_wr && mem_rd == rs) return 2'd1;
      if (rs != 5'd0 && wb_valid && wb_rd_wr && wb_rd == rs) return 2'd2;
      return 2'd0;
   endfunction

   // Layout: {req, timeout, redirect[1:0], fwd_a[1:0], fwd_b[1:0], pc/ifid/idex/exmem stall, ifid/idex/exmem/memwb flush}
   function automatic logic [15:0] model_eval();
      logic       req, tmo, hold, kill, lu, done;
      logic [1:0] redir;
      logic [7:0] sf;
      req = 1'b0; tmo = 1'b0; hold = 1'b0; kill = 1'b0; redir = 2'd0; sf = 8'h00;
      if (rst) return 16'h0000;
      if (!m_pend) begin
         if (mem_acc && !trap) begin req = 1'b1; hold = 1'b1; end
      end else begin
         done = dmem_if.dmem_ack || (m_waits == TMO - 1);
         if (done) tmo = !dmem_if.dmem_ack;
         else if (m_kill) kill = 1'b1;
         else hold = 1'b1;
      end
      lu = ex_valid && ex_mem_read && ex_rd != 5'd0 &&
           ((id_rs1_rd && id_rs1 == ex_rd) || (id_rs2_rd && id_rs2 == ex_rd));
      if (trap) begin sf = 8'b0000_1111; redir = 2'd2; end
      else if (hold) sf = 8'b1111_0001;
      else if (kill) sf = 8'b1000_1111;
      else if (misp) begin sf = 8'b0000_1100; redir = 2'd1; end
      else if (lu) sf = 8'b1100_0100;
      return {req, tmo, redir, ref_fwd(ex_rs1), ref_fwd(ex_rs2), sf};
   endfunction

   function automatic logic [15:0] observe();
      return {dmem_if.dmem_req, dmem_if.dmem_timeout, redirect, fwd_a, fwd_b,
              pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
              if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};
   endfunction

   task automatic tick();
      if (rst) begin
         m_pend = 1'b0; m_kill = 1'b0; m_waits = 0;
      end else if (!m_pend) begin
         if (mem_acc && !trap) begin m_pend = 1'b1; m_kill = 1'b0; m_waits = 0; end
      end else if (dmem_if.dmem_ack || m_waits == TMO - 1) begin
         m_pend = 1'b0;
      end else begin
         m_waits++;
         if (trap) m_kill = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rs1 = 5'd0; ex_rs2 = 5'd0; ex_rd = 5'd0;
      mem_rd = 5'd0; wb_rd = 5'd0; id_rs1_rd = 1'b0; id_rs2_rd = 1'b0;
      ex_valid = 1'b0; ex_mem_read = 1'b0; ex_rd_wr = 1'b0; misp = 1'b0;
      mem_valid = 1'b0; mem_rd_wr = 1'b0; mem_acc = 1'b0;
      wb_valid = 1'b0; wb_rd_wr = 1'b0; trap = 1'b0; dmem_if.dmem_ack = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1; mem_acc = 1'b1; mem_valid = 1'b1; mem_rd_wr = 1'b1; mem_rd = 5'd3; ex_rs1 = 5'd3;
      for (int c = 0; c < 2; c++) begin
         #1; obs_v = observe(); n_checks++;
         if (obs_v !== 16'h0000) begin n_fails++; $display("FAIL reset_outputs: got %h expected 0000", obs_v); end
         tick();
      end
      rst = 1'b0; clear_inputs();
      #1; obs_v = observe(); n_checks++;
      if (obs_v !== 16'h0000) begin n_fails++; $display("FAIL reset_idle: got %h expected 0000", obs_v); end
      tick();
      // Reset in the middle of WAIT must return to IDLE.
      mem_acc = 1'b1;
      for (int c = 0; c < 2; c++) begin
         #1; exp_v = model_eval(); obs_v = observe(); n_checks++;
         if (obs_v !== exp_v) begin n_fails++; $display("FAIL reset_pre_wait%0d: got %h expected %h", c, obs_v, exp_v); end
         tick();
      end
      rst = 1'b1;
      #1; obs_v = observe(); n_checks++;
      if (obs_v !== 16'h0000) begin n_fails++; $display("FAIL reset_mid_wait: got %h expected 0000", obs_v); end
      tick();
      rst = 1'b0;
      #1; obs_v = observe(); n_checks++;
      if (obs_v !== 16'h80F1) begin n_fails++; $display("FAIL reset_reissue: got %h expected 80f1", obs_v); end
      tick();
      dmem_if.dmem_ack = 1'b1;
      #1; obs_v = observe(); n_checks++;
      if (obs_v !== 16'h0000) begin n_fails++; $display("FAIL reset_drain_ack: got %h expected 0000", obs_v); end
      tick();
      clear_inputs();
   endtask

   task automatic test_load_use();
      clear_inputs();
      ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd_wr = 1'b1; ex_rd = 5'd5;
      id_rs1 = 5'd5; id_rs1_rd = 1'b1; id_rs2 = 5'd1; id_rs2_rd = 1'b1;
      #1; obs_v = observe(); n_checks++;
      if (obs_v !== 16'h00C4) begin n_fails++; $display("FAIL load_use_bubble: got %h expected 00c4", obs_v); end
      tick();
      clear_inputs();
      ex_valid = 1'b1; ex_rs1 = 5'd5; ex_rs2 = 5'd1;
      wb_valid = 1'b1; wb_rd_wr = 1'b1; wb_rd = 5'd5;
      #1; obs_v = observe(); n_checks++;
      if (obs_v !== 16'h0800) begin n_fails++; $display("FAIL load_use_fwd_wb: got %h expected 0800", obs_v); end
      tick();
      clear_inputs();
   endtask

   task automatic test_forward();
      clear_inputs();
      mem_valid = 1'b1; mem_rd_wr = 1'b1; mem_rd = 5'd7;
      wb_valid = 1'b1; wb_rd_wr = 1'b1; wb_rd = 5'd7; ex_rs1 = 5'd7;
      #1; obs_v = observe(); n_checks++;
      if (obs_v !== 16'h0400) begin n_fails++; $display("FAIL fwd_mem_priority: got %h expected 0400", obs_v); end
      tick();
      mem_rd = 5'd0; wb_rd = 5'd0; ex_rs1 = 5'd0; ex_rs2 = 5'd0;
      #1; obs_v = observe(); n_checks++;
      if (obs_v !== 16'h0000) begin n_fails++; $display("FAIL fwd_x0: got %h expected 0000", obs_v); end
      tick();
      mem_rd = 5'd9; wb_rd = 5'd7; ex_rs2 = 5'd7;
      #1; obs_v = observe(); n_checks++;
      if (obs_v !== 16'h0200) begin n_fails++; $display("FAIL fwd_wb_b: got %h expected 0200", obs_v); end
      tick();
      clear_inputs();
   endtask

   task automatic test_dmem_ack();
      int n_req = 0, n_stall = 0, n_mwf = 0;
      clear_inputs();
      mem_acc = 1'b1;
      for (int c = 0; c < 4; c++) begin
         dmem_if.dmem_ack = (c == 3);
         #1; exp_v = model_eval(); obs_v = observe(); n_checks++;
         if (obs_v !== exp_v) begin n_fails++; $display("FAIL dmem_ack_cyc%0d: got %h expected %h", c, obs_v, exp_v); end
         n_req += int'(dmem_if.dmem_req); n_stall += int'(pc_stall); n_mwf += int'(mem_wb_flush);
         tick();
      end
      n_checks++;
      if (n_req != 1 || n_stall != 3 || n_mwf != 3) begin
         n_fails++; $display("FAIL dmem_ack_counts: got req=%0d stall=%0d mwf=%0d expected 1/3/3", n_req, n_stall, n_mwf);
      end
      clear_inputs();
   endtask

   task automatic test_timeout();
      int tmo_cyc = -1, n_tmo = 0;
      clear_inputs();
      mem_acc = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1; exp_v = model_eval(); obs_v = observe(); n_checks++;
         if (obs_v !== exp_v) begin n_fails++; $display("FAIL timeout_cyc%0d: got %h expected %h", c, obs_v, exp_v); end
         if (dmem_if.dmem_timeout) begin tmo_cyc = c; n_tmo++; end
         tick();
      end
      n_checks++;
      if (tmo_cyc != 4 || n_tmo != 1) begin n_fails++; $display("FAIL timeout_when: got cyc=%0d n=%0d expected 4/1", tmo_cyc, n_tmo); end
      #1; obs_v = observe(); n_checks++;
      if (obs_v !== 16'h80F1) begin n_fails++; $display("FAIL timeout_idle_after: got %h expected 80f1", obs_v); end
      tick();
      dmem_if.dmem_ack = 1'b1;
      #1; obs_v = observe(); n_checks++;
      if (obs_v !== 16'h0000) begin n_fails++; $display("FAIL timeout_drain: got %h expected 0000", obs_v); end
      tick();
      clear_inputs();
   endtask

   task automatic test_trap_kill();
      logic [15:0] want [5] = '{16'h80F1, 16'h00F1, 16'h200F, 16'h008F, 16'h0000};
      clear_inputs();
      for (int c = 0; c < 5; c++) begin
         mem_acc = (c < 2); trap = (c == 2); misp = (c == 2 || c == 3); dmem_if.dmem_ack = (c == 4);
         #1; exp_v = model_eval(); obs_v = observe(); n_checks += 2;
         if (obs_v !== want[c]) begin n_fails++; $display("FAIL trap_kill_cyc%0d: got %h expected %h", c, obs_v, want[c]); end
         if (obs_v !== exp_v) begin n_fails++; $display("FAIL trap_kill_model%0d: got %h expected %h", c, obs_v, exp_v); end
         tick();
      end
      clear_inputs();
   endtask

   task automatic test_mispredict_loaduse();
      clear_inputs();
      ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd_wr = 1'b1; ex_rd = 5'd3; misp = 1'b1;
      id_rs1 = 5'd3; id_rs1_rd = 1'b1;
      #1; obs_v = observe(); n_checks++;
      if (obs_v !== 16'h100C) begin n_fails++; $display("FAIL misp_over_loaduse: got %h expected 100c", obs_v); end
      tick();
      clear_inputs();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         rst = ($urandom_range(0, 63) == 0);
         id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
         ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
         ex_rd = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3)); wb_rd = 5'($urandom_range(0, 3));
         id_rs1_rd = 1'($urandom_range(0, 1)); id_rs2_rd = 1'($urandom_range(0, 1));
         ex_valid = 1'($urandom_range(0, 1)); ex_mem_read = 1'($urandom_range(0, 1)); ex_rd_wr = 1'($urandom_range(0, 1));
         mem_valid = 1'($urandom_range(0, 1)); mem_rd_wr = 1'($urandom_range(0, 1));
         wb_valid = 1'($urandom_range(0, 1)); wb_rd_wr = 1'($urandom_range(0, 1));
         mem_acc = ($urandom_range(0, 2) == 0); misp = ($urandom_range(0, 7) == 0);
         trap = ($urandom_range(0, 15) == 0); dmem_if.dmem_ack = ($urandom_range(0, 4) == 0);
         #1; exp_v = model_eval(); obs_v = observe(); n_checks++;
         if (obs_v !== exp_v) begin n_fails++; $display("FAIL random_cyc%0d: got %h expected %h", c, obs_v, exp_v); end
         tick();
      end
      rst = 1'b0;
      clear_inputs();
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      m_pend = 1'b0; m_kill = 1'b0; m_waits = 0;
      @(negedge clk);
      test_reset();
      test_load_use();
      test_forward();
      test_dmem_ack();
      test_timeout();
      test_trap_kill();
      test_mispredict_loaduse();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
